// File: rtl/cpu_pkg.sv
// Shared CPU encodings: hazard FSM states and EX-stage operand forwarding selects.
// The forwarding encoding is also used by the ExecUnit operand muxes.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Operand forwarding select for one EX source register.
// The MEM-stage ALU result takes priority over the WB value. A load in MEM
// cannot forward because its data is not available until WB. $0 never forwards.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            mem_regwr,
  input  logic            mem_memtoreg,
  input  logic [RA_W-1:0] mem_rw,
  input  logic            wb_regwr,
  input  logic [RA_W-1:0] wb_rw,
  output logic [1:0]      fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwr && !mem_memtoreg && (mem_rw != '0) && (mem_rw == src);
  assign wb_hit  = wb_regwr && (wb_rw != '0) && (wb_rw == src);

  // Priority select: MEM over WB over the register file.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    fwd = FWD_RF;
    if (mem_hit)     fwd = FWD_MEM;
    else if (wb_hit) fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage datapath. It detects load-use and taken
// branch hazards and drives the PC, IF/ID and ID/EX controls with zero latency.
// It also drives the EX forwarding selects. A private shadow copy of the
// EX/MEM/WB destination and control fields means it needs no pipeline taps.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rw,
  input  logic             id_regwr,
  input  logic             id_memtoreg,
  input  logic             id_branch,
  input  logic             ex_br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel_br,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic [RA_W-1:0] rw;
    logic            regwr;
    logic            memtoreg;
    logic            branch;
  } shadow_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_e state;
  shadow_t   id_s, ex_q, mem_q, wb_q;
  logic      load_use, br, take_br, take_lu;
  logic      shadow_unused;

  assign id_s = '{rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt,
                  rw: id_rw, regwr: id_regwr, memtoreg: id_memtoreg,
                  branch: id_branch};

  // Hazard terms are only acted upon in RUN. In LU_STALL and BR_FLUSH the EX
  // stage holds a bubble, so the controls stay at their defaults.
  assign load_use = ex_q.memtoreg && ex_q.regwr && (ex_q.rw != '0) &&
                    ((id_use_rs && (id_rs == ex_q.rw)) ||
                     (id_use_rt && (id_rt == ex_q.rw)));
  assign br       = ex_q.branch && ex_br_taken;
  assign take_br  = (state == ST_RUN) && br;
  assign take_lu  = (state == ST_RUN) && load_use && !br;

  // Combinational pipeline controls from the current hazard decision.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_sel_br   = 1'b0;
    if (take_br) begin
      pc_sel_br   = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (take_lu) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // FSM, shadow pipeline and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates let MEM take the old EX and WB take the old MEM on the same edge.
      if (take_br)      state <= ST_BR_FLUSH;
      else if (take_lu) state <= ST_LU_STALL;
      else              state <= ST_RUN;
      ex_q  <= idex_bubble ? '0 : id_s;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (take_lu && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (take_br && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // Shadow fields kept for completeness but not needed by the decision logic.
  assign shadow_unused = ^{ex_q.use_rs, ex_q.use_rt, mem_q, wb_q};

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .src          (ex_q.rs),
    .mem_regwr    (mem_q.regwr),
    .mem_memtoreg (mem_q.memtoreg),
    .mem_rw       (mem_q.rw),
    .wb_regwr     (wb_q.regwr),
    .wb_rw        (wb_q.rw),
    .fwd          (fwd_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .src          (ex_q.rt),
    .mem_regwr    (mem_q.regwr),
    .mem_memtoreg (mem_q.memtoreg),
    .mem_rw       (mem_q.rw),
    .wb_regwr     (wb_q.regwr),
    .wb_rw        (wb_q.rw),
    .fwd          (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs
// are sampled 1 time unit later, well before the next rising edge.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_rw;
  logic        id_use_rs, id_use_rt, id_regwr, id_memtoreg, id_branch, ex_br_taken;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_br;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rw       (id_rw),
    .id_regwr    (id_regwr),
    .id_memtoreg (id_memtoreg),
    .id_branch   (id_branch),
    .ex_br_taken (ex_br_taken),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pc_sel_br   (pc_sel_br),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one ID-stage instruction plus the EX branch outcome.
  task automatic id_in(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rw,
                       input logic rwr, input logic mtr, input logic brn,
                       input logic tk);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_rw = rw;
    id_regwr = rwr; id_memtoreg = mtr; id_branch = brn; ex_br_taken = tk;
  endtask

  task automatic nop();
    id_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one rising edge, ending on the next falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (4) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    nop();
    cycle(); cycle();
    #1;
    check("rst_pc_we",    pc_we,       1);
    check("rst_ifid_we",  ifid_we,     1);
    check("rst_flush",    ifid_flush,  0);
    check("rst_bubble",   idex_bubble, 0);
    check("rst_sel_br",   pc_sel_br,   0);
    check("rst_fwd",      {fwd_a, fwd_b}, 4'b0000);
    check("rst_cnt",      stall_cnt | flush_cnt, 0);
    reset = 1'b0;
    cycle();

    // 1. lw $2,0($1); add $3,$2,$4
    id_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    check("t1_lw_no_stall", pc_we, 1);
    cycle();
    id_in(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t1_pc_we",  pc_we,       0);
    check("t1_ifid_we", ifid_we,    0);
    check("t1_bubble", idex_bubble, 1);
    check("t1_sel_br", pc_sel_br,   0);
    cycle(); #1;
    check("t1_stall_released", {pc_we, ifid_we, idex_bubble}, 3'b110);
    check("t1_stall_cnt", stall_cnt, 1);
    cycle();
    nop(); #1;
    check("t1_fwd_a_wb", fwd_a, 2'b10);
    check("t1_fwd_b_rf", fwd_b, 2'b00);
    drain();

    // 2. add $2,$1,$1; sub $3,$2,$2
    id_in(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    id_in(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t2_no_stall", {pc_we, ifid_we, idex_bubble}, 3'b110);
    cycle();
    nop(); #1;
    check("t2_fwd_a_mem", fwd_a, 2'b01);
    check("t2_fwd_b_mem", fwd_b, 2'b01);
    drain();

    // 3. add $2..; nop; or $5,$2,$0
    id_in(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop();
    cycle();
    id_in(5'd2, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop(); #1;
    check("t3_fwd_a_wb", fwd_a, 2'b10);
    check("t3_fwd_b_rf", fwd_b, 2'b00);
    drain();

    // 3b. Double match: add $2; add $2; or $5,$2,$2 -> MEM wins
    id_in(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    id_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    id_in(5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop(); #1;
    check("t3b_mem_priority", {fwd_a, fwd_b}, 4'b0101);
    drain();

    // 4. beq taken; the add $7 behind it is squashed
    id_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    id_in(5'd1, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    check("t4_sel_br", pc_sel_br,   1);
    check("t4_flush",  ifid_flush,  1);
    check("t4_bubble", idex_bubble, 1);
    check("t4_pc_we",  pc_we,       1);
    cycle();
    id_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("t4_flush_done", {pc_sel_br, ifid_flush, idex_bubble}, 3'b000);
    check("t4_flush_cnt", flush_cnt, 1);
    cycle();
    nop();
    cycle();
    id_in(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop(); #1;
    check("t4_squashed_no_fwd", {fwd_a, fwd_b}, 4'b0000);
    drain();

    // 5. EX holds a load-to-$2 that is also a taken branch; ID reads $2
    id_in(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    id_in(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    check("t5_sel_br", pc_sel_br, 1);
    check("t5_pc_we",  pc_we,     1);
    check("t5_ifid_we", ifid_we,  1);
    check("t5_bubble", idex_bubble, 1);
    cycle();
    nop(); #1;
    check("t5_stall_cnt", stall_cnt, 1);
    check("t5_flush_cnt", flush_cnt, 2);
    drain();

    // 6a. Writes to $0 never stall or forward
    id_in(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    id_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t6_r0_no_stall", {pc_we, ifid_we, idex_bubble}, 3'b110);
    cycle();
    id_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    nop(); #1;
    check("t6_r0_no_fwd", {fwd_a, fwd_b}, 4'b0000);
    drain();

    // 6b. Reset asserted during LU_STALL
    id_in(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    id_in(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t6_stall_again", pc_we, 0);
    cycle(); #1;
    check("t6_in_lu_stall", dut.state, ST_LU_STALL);
    check("t6_stall_cnt2", stall_cnt, 2);
    reset = 1'b1; #1;
    check("t6_rst_state", dut.state, ST_RUN);
    check("t6_rst_cnt", stall_cnt | flush_cnt, 0);
    check("t6_rst_pc_we", pc_we, 1);
    cycle();
    reset = 1'b0;
    cycle();
    id_in(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t6_shadow_cleared", {pc_we, ifid_we, idex_bubble}, 3'b110);
    check("t6_fwd_cleared", {fwd_a, fwd_b}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
